// File: rtl/rvsteel_uart_receiver.sv
// rvsteel_uart_receiver
//   UART receiver (8N1, LSB first) with a first-word-fall-through receive FIFO.
//   The line is synchronised, the start bit is confirmed at mid-bit, and each
//   following bit is sampled one bit period later, which lands near mid-bit.
//   Completed bytes drain over a valid/ready handshake.
//   Optional macro UART_RX_PARITY_EN: 8E1 framing with an even-parity check.
module rvsteel_uart_receiver #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int UART_BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_error,
    output logic                          overrun_error
);

    localparam int CYCLES_PER_BAUD = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int BAUD_W          = $clog2(CYCLES_PER_BAUD + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CYCLES_PER_BAUD - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CYCLES_PER_BAUD / 2);
    localparam int PTR_W           = $clog2(FIFO_DEPTH);
    localparam int CNT_W           = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
    } state_t;
`endif

    logic              sync_meta_q, sync_meta_d;
    logic              sync_line_q, sync_line_d;
    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic              parity_q, parity_d;
`endif
    logic              frame_error_q, frame_error_d;
    logic              overrun_error_q, overrun_error_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        fifo_mem_q [FIFO_DEPTH];

    logic              line;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              push_ok;

    assign line = sync_line_q;

    // Two-flop synchroniser for the asynchronous serial line.
    always_comb begin
        sync_meta_d = uart_rx;
        sync_line_d = sync_meta_q;
    end

    // Frame FSM: start-bit validation, bit sampling, stop/parity checking.
    always_comb begin
        state_d       = state_q;
        baud_cnt_d    = baud_cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
`ifdef UART_RX_PARITY_EN
        parity_d      = parity_q;
`endif
        frame_error_d = 1'b0;
        push          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!line) begin
                    state_d    = START;
                    baud_cnt_d = '0;
                end
            end
            START: begin
                if (baud_cnt_q == BAUD_HALF) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = line ? IDLE : DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d         = '0;
                    shift_d[bit_idx_q] = line;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    parity_d   = line;
                    state_d    = STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (line) begin
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, parity_q}) begin
                            frame_error_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
`else
                        push = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = BREAK;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (line) begin
                    state_d    = IDLE;
                    baud_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = '0;
            end
        endcase
    end

    // FIFO bookkeeping: a pop frees a slot in the same cycle, so a push into a
    // full FIFO that coincides with a pop is accepted rather than dropped.
    always_comb begin
        pop             = rx_valid && rx_ready;
        fifo_full       = (count_q == FIFO_FULL);
        push_ok         = push && (!fifo_full || pop);
        overrun_error_d = push && fifo_full && !pop;
        wr_ptr_d        = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d        = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d         = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    // State register for synchroniser, FSM, error pulses and FIFO pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta_q     <= 1'b1;
            sync_line_q     <= 1'b1;
            state_q         <= IDLE;
            baud_cnt_q      <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
`ifdef UART_RX_PARITY_EN
            parity_q        <= 1'b0;
`endif
            frame_error_q   <= 1'b0;
            overrun_error_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            sync_meta_q     <= sync_meta_d;
            sync_line_q     <= sync_line_d;
            state_q         <= state_d;
            baud_cnt_q      <= baud_cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
`ifdef UART_RX_PARITY_EN
            parity_q        <= parity_d;
`endif
            frame_error_q   <= frame_error_d;
            overrun_error_q <= overrun_error_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    // FIFO storage; contents need no reset because the count gates visibility.
    always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
            fifo_mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_valid      = (count_q != '0);
    assign rx_data       = rx_valid ? fifo_mem_q[rd_ptr_q] : 8'h00;
    assign rx_count      = count_q;
    assign frame_error   = frame_error_q;
    assign overrun_error = overrun_error_q;

endmodule

// File: tb/tb_rvsteel_uart_receiver.sv
// tb_rvsteel_uart_receiver
//   Directed bench for rvsteel_uart_receiver using a short bit period
//   (16 clocks per bit) so whole frames stay cheap to simulate.
module tb_rvsteel_uart_receiver;

   localparam int CLK_HZ  = 160;
   localparam int BAUD    = 10;
   localparam int CPB     = CLK_HZ / BAUD;
   localparam int DEPTH   = 8;
`ifdef UART_RX_PARITY_EN
   localparam int PAYLOAD_BITS = 9;
`else
   localparam int PAYLOAD_BITS = 8;
`endif
   // Clock edge (counted from the start-bit edge) at which the stop bit is
   // sampled: 2 synchroniser cycles, 1 cycle to leave IDLE, half a bit to
   // confirm the start bit, 1 cycle to enter DATA, then one period per bit.
   localparam int PUSH_EDGE = 4 + CPB / 2 + CPB * (PAYLOAD_BITS + 1);

   logic         clock;
   logic         reset;
   logic         uart_rx;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         rx_ready;
   logic [3:0]   rx_count;
   logic         frame_error;
   logic         overrun_error;

   int checks;
   int errors;
   int frameErrSeen;
   int overrunSeen;
   int expFrameErr;
   int expOverrun;

   rvsteel_uart_receiver #(
      .CLOCK_FREQUENCY(CLK_HZ),
      .UART_BAUD_RATE (BAUD),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .uart_rx      (uart_rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_count     (rx_count),
      .frame_error  (frame_error),
      .overrun_error(overrun_error)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Count cycles each error pulse is high, sampled away from the active edge.
   always @(negedge clock) begin
      if (frame_error) frameErrSeen++;
      if (overrun_error) overrunSeen++;
   end

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Payload bits on the wire: data LSB first, then even parity when enabled.
   function automatic logic [8:0] makeBits(input logic [7:0] data, input logic flip);
      return {(^data) ^ flip, data};
   endfunction

   // Drive one frame on the line, starting at the next falling clock edge.
   task automatic applyStimulus(input logic [8:0] bits, input logic stopLevel,
                                input int stopBits);
      @(negedge clock);
      uart_rx = 1'b0;
      repeat (CPB - 1) @(negedge clock);
      for (int i = 0; i < PAYLOAD_BITS; i++) begin
         @(negedge clock);
         uart_rx = bits[i];
         repeat (CPB - 1) @(negedge clock);
      end
      @(negedge clock);
      uart_rx = stopLevel;
      repeat (CPB * stopBits - 1) @(negedge clock);
      @(negedge clock);
      uart_rx = 1'b1;
      repeat (3) @(negedge clock);
   endtask

   // Check the head byte then pop it with a one-cycle ready pulse.
   task automatic popByte(input string tag, input logic [7:0] expected);
      checkOutput(tag, rx_data, expected);
      rx_ready = 1'b1;
      @(negedge clock);
      rx_ready = 1'b0;
   endtask

   // Directed sequence.
   initial begin
      checks       = 0;
      errors       = 0;
      frameErrSeen = 0;
      overrunSeen  = 0;
      expFrameErr  = 0;
      expOverrun   = 0;
      reset        = 1'b1;
      uart_rx      = 1'b1;
      rx_ready     = 1'b0;

      repeat (4) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset_valid", rx_valid, 1'b0);
      checkOutput("reset_data", rx_data, 8'h00);
      checkOutput("reset_count", rx_count, 4'd0);
      checkOutput("reset_ferr", frame_error, 1'b0);
      checkOutput("reset_oerr", overrun_error, 1'b0);

      // rx_ready while empty must not disturb anything.
      rx_ready = 1'b1;
      repeat (3) @(negedge clock);
      rx_ready = 1'b0;
      checkOutput("ready_empty_count", rx_count, 4'd0);

      // Two clean bytes, FWFT head and drain order.
      applyStimulus(makeBits(8'h55, 1'b0), 1'b1, 1);
      checkOutput("b55_valid", rx_valid, 1'b1);
      checkOutput("b55_data", rx_data, 8'h55);
      checkOutput("b55_count", rx_count, 4'd1);
      applyStimulus(makeBits(8'hA3, 1'b0), 1'b1, 1);
      checkOutput("bA3_count", rx_count, 4'd2);
      checkOutput("bA3_head", rx_data, 8'h55);
      popByte("pop_55", 8'h55);
      checkOutput("after_pop1_count", rx_count, 4'd1);
      popByte("pop_A3", 8'hA3);
      checkOutput("after_pop2_count", rx_count, 4'd0);
      checkOutput("after_pop2_valid", rx_valid, 1'b0);

      // Short low glitch (well under half a bit) is rejected silently.
      uart_rx = 1'b0;
      repeat (5) @(negedge clock);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clock);
      checkOutput("glitch_count", rx_count, 4'd0);
      checkOutput("glitch_ferr", frameErrSeen, expFrameErr);

      // Stop bit held low for three bit times: one frame error, then recovery.
      applyStimulus(makeBits(8'h3C, 1'b0), 1'b0, 3);
      expFrameErr++;
      checkOutput("break_ferr", frameErrSeen, expFrameErr);
      checkOutput("break_count", rx_count, 4'd0);
      applyStimulus(makeBits(8'h81, 1'b0), 1'b1, 1);
      checkOutput("b81_count", rx_count, 4'd1);
      popByte("pop_81", 8'h81);

      // Overrun: nine bytes with no consumer, ninth is dropped.
      for (int i = 0; i <= DEPTH; i++) begin
         applyStimulus(makeBits(8'(i), 1'b0), 1'b1, 1);
      end
      expOverrun++;
      checkOutput("ovr_count", rx_count, 4'd8);
      checkOutput("ovr_pulses", overrunSeen, expOverrun);
      checkOutput("ovr_ferr", frameErrSeen, expFrameErr);
      for (int i = 0; i < DEPTH; i++) begin
         popByte($sformatf("ovr_drain_%0d", i), 8'(i));
      end
      checkOutput("ovr_drained", rx_count, 4'd0);

      // Full FIFO with a pop exactly in the push cycle of the ninth byte.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(makeBits(8'h10 + 8'(i), 1'b0), 1'b1, 1);
      end
      checkOutput("full_count", rx_count, 4'd8);
      fork
         applyStimulus(makeBits(8'h18, 1'b0), 1'b1, 1);
         begin
            repeat (PUSH_EDGE) @(negedge clock);
            rx_ready = 1'b1;
            @(negedge clock);
            rx_ready = 1'b0;
         end
      join
      checkOutput("simul_count", rx_count, 4'd8);
      checkOutput("simul_oerr", overrunSeen, expOverrun);
      for (int i = 1; i <= DEPTH; i++) begin
         popByte($sformatf("simul_drain_%0d", i), 8'h10 + 8'(i));
      end
      checkOutput("simul_drained", rx_count, 4'd0);

      // Reset in the middle of the data bits of 0x7E flushes everything.
      applyStimulus(makeBits(8'h99, 1'b0), 1'b1, 1);
      checkOutput("pre_reset_count", rx_count, 4'd1);
      @(negedge clock);
      uart_rx = 1'b0;
      repeat (CPB - 1) @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         uart_rx = (i != 0);
         repeat (CPB - 1) @(negedge clock);
      end
      reset   = 1'b1;
      uart_rx = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midreset_valid", rx_valid, 1'b0);
      checkOutput("midreset_count", rx_count, 4'd0);
      checkOutput("midreset_data", rx_data, 8'h00);
      applyStimulus(makeBits(8'h42, 1'b0), 1'b1, 1);
      checkOutput("b42_count", rx_count, 4'd1);
      popByte("pop_42", 8'h42);
      checkOutput("final_ferr", frameErrSeen, expFrameErr);
      checkOutput("final_oerr", overrunSeen, expOverrun);

`ifdef UART_RX_PARITY_EN
      // Corrupted parity is a frame error and the byte is discarded.
      applyStimulus(makeBits(8'h42, 1'b1), 1'b1, 1);
      expFrameErr++;
      checkOutput("parity_ferr", frameErrSeen, expFrameErr);
      checkOutput("parity_count", rx_count, 4'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
